// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through data cache: FSM encoding,
// default geometry and the index-width helper.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

    localparam int DEF_D_WIDTH = 8;
    localparam int DEF_A_WIDTH = 8;
    localparam int DEF_LINES   = 4;
    localparam int DEF_RAM_LAT = 1;

    function automatic int idx_width(input int lines);
        return (lines > 1) ? $clog2(lines) : 1;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational lookup,
// single synchronous line write port. Only the valid bits are reset.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int LINES   = DEF_LINES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [A_WIDTH-1:0] lookup_addr,
    output logic               hit,
    output logic [D_WIDTH-1:0] hit_data,
    input  logic               line_we,
    input  logic [A_WIDTH-1:0] line_addr,
    input  logic [D_WIDTH-1:0] line_data
);

    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = A_WIDTH - IDX_W;

    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [D_WIDTH-1:0] data_q [LINES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign lk_idx = lookup_addr[IDX_W-1:0];
    assign lk_tag = lookup_addr[A_WIDTH-1:IDX_W];
    assign wr_idx = line_addr[IDX_W-1:0];
    assign wr_tag = line_addr[A_WIDTH-1:IDX_W];

    assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign hit_data = data_q[lk_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // A write hit rewrites the same tag, so fill and update share one port.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= line_data;
        end
    end

endmodule

// File: rtl/data_cache_wt.sv
// Direct-mapped write-through, write-no-allocate data cache in front of the data RAM.
// Optional hit/miss counters are enabled with DATA_CACHE_STATS_EN.
module data_cache_wt
    import dcache_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int LINES   = DEF_LINES,
    parameter int RAM_LAT = DEF_RAM_LAT
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               rd,
    input  logic               wr,
    output logic [D_WIDTH-1:0] rdata,
    output logic               odv,
    output logic               busy,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_wdata,
    output logic               ram_we,
    output logic               ram_re,
    input  logic [D_WIDTH-1:0] ram_rdata
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [7:0]         hit_cnt,
    output logic [7:0]         miss_cnt
`endif
);

    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    state_e             state_q, state_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic               odv_q, odv_d;

    logic [A_WIDTH-1:0] lookup_addr;
    logic               hit;
    logic [D_WIDTH-1:0] hit_data;
    logic               line_we;
    logic [D_WIDTH-1:0] line_data;

    // In IDLE the request address is looked up directly; afterwards the latched one.
    assign lookup_addr = (state_q == ST_IDLE) ? addr : addr_q;

    dcache_line_array #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .LINES   (LINES)
    ) u_lines (
        .clk         (g_clk),
        .rst_n       (g_clr),
        .lookup_addr (lookup_addr),
        .hit         (hit),
        .hit_data    (hit_data),
        .line_we     (line_we),
        .line_addr   (addr_q),
        .line_data   (line_data)
    );

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            odv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            odv_q   <= odv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        odv_d     = 1'b0;
        line_we   = 1'b0;
        line_data = ram_rdata;
        unique case (state_q)
            ST_IDLE: begin
                if (wr || rd) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                end
                if (wr) begin
                    state_d = ST_WRITE;
                end else if (rd) begin
                    if (hit) begin
                        rdata_d = hit_data;
                        odv_d   = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(RAM_LAT - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    line_we   = 1'b1;
                    line_data = ram_rdata;
                    rdata_d   = ram_rdata;
                    odv_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: begin
                line_we   = hit;
                line_data = wdata_q;
                odv_d     = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        ram_re    = (state_q == ST_FILL);
        ram_we    = (state_q == ST_WRITE);
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        rdata     = rdata_q;
        odv       = odv_q;
    end

`ifdef DATA_CACHE_STATS_EN
    logic [7:0] hit_cnt_q, miss_cnt_q;
    logic       rd_hit_evt, rd_miss_evt;

    assign rd_hit_evt  = (state_q == ST_IDLE) && rd && !wr && hit;
    assign rd_miss_evt = (state_q == ST_WAIT) && (cnt_q == '0);

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit_evt && hit_cnt_q != 8'hFF) begin
                hit_cnt_q <= hit_cnt_q + 8'd1;
            end
            if (rd_miss_evt && miss_cnt_q != 8'hFF) begin
                miss_cnt_q <= miss_cnt_q + 8'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/data_cache_wt.md
Name: data_cache_wt

Overview:
- Direct-mapped, write-through, write-no-allocate data cache for the stage-three memory path.
- Sits between the pipeline's data-address/data-bus logic (fed from PSR1 and the register file via the data-cache address mux) and the 256x8 data RAM.
- Reports completion to the controller with a one-cycle odv pulse.
- Holds busy so the controller stalls the pipeline on misses and writes.

Parameters:
- D_WIDTH, 8, data word width.
- A_WIDTH, 8, byte address width.
- LINES, 4, number of cache lines; power of two, at least 2; index = addr[log2(LINES)-1:0], tag = remaining upper bits.
- RAM_LAT, 1, cycles from ram_re strobe to ram_rdata valid; at least 1.

Ports:
- g_clk  in  1  system clock, rising edge.
- g_clr  in  1  asynchronous active-low reset.
- addr  in  A_WIDTH  request byte address.
- wdata  in  D_WIDTH  write data.
- rd  in  1  read request, sampled only when busy=0.
- wr  in  1  write request, sampled only when busy=0.
- rdata  out  D_WIDTH  read result, valid when odv=1, held until the next read completes.
- odv  out  1  operation-done pulse, one cycle.
- busy  out  1  high while not in IDLE.
- ram_addr  out  A_WIDTH  data RAM address.
- ram_wdata  out  D_WIDTH  data RAM write data.
- ram_we  out  1  data RAM write strobe, one cycle.
- ram_re  out  1  data RAM read strobe, one cycle.
- ram_rdata  in  D_WIDTH  data RAM read data.

Behaviour:
- Reset (g_clr=0, asynchronous):
  - All valid bits cleared; tag and data arrays are not reset.
  - FSM enters IDLE.
  - rdata=0, odv=0, busy=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0.
  - Reset during FILL or WRITE aborts the operation; no odv is issued and no line is updated.
- States: IDLE, FILL, WAIT, WRITE.
- IDLE:
  - Latch addr/wdata on any accepted request.
  - wr has priority if rd and wr are asserted together; rd is ignored in that case.
- Read hit: line valid and tag equal. Stay in IDLE; next edge rdata=line data, odv=1. Latency is 1 cycle.
- Read miss: go to FILL.
  - FILL (1 cycle): ram_re=1, ram_addr=latched address. Go to WAIT with counter=RAM_LAT-1.
  - WAIT: count down. At 0, capture ram_rdata into the line, write the tag, set valid, set rdata, pulse odv, return to IDLE.
  - Miss latency is RAM_LAT+2 cycles from the request edge to odv.
- Write (hit or miss): go to WRITE.
  - WRITE (1 cycle): ram_we=1, ram_addr and ram_wdata from the latched values.
  - On a hit, the line data is updated at the same edge. A miss does not allocate.
  - odv pulses the following cycle while the FSM returns to IDLE. Write latency is 2 cycles.
- rd/wr while busy=1 are ignored; the controller holds the request until odv.
- Back-to-back operation: a new request is accepted in the same cycle odv is high (FSM already in IDLE).
- Address wrap-around is not applicable: addresses 8'hFF and 8'h00 map to their index normally.
- ram_re and ram_we are never high together.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[7:0] and miss_cnt[7:0], both reset to 0 by g_clr.
  - Each counts completed read hits / read misses and saturates at 8'hFF.
  - Writes are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `dcache_pkg`:
  - FSM state encoding (IDLE=2'b00, FILL=2'b01, WAIT=2'b10, WRITE=2'b11).
  - Default D_WIDTH, A_WIDTH, LINES, RAM_LAT constants.
  - Width function for the index.
- Sub-module `dcache_line_array`: valid/tag/data storage with a combinational hit output and a synchronous line write port. The top module holds the FSM, latches and RAM strobes.

Test Plan:
- Reset, then rd addr=8'h05 (cold miss) with RAM[5]=8'hA5 and RAM_LAT=1 -> ram_re pulse at cycle 1 with ram_addr=8'h05; odv and rdata=8'hA5 at cycle 3; busy high in cycles 1-2.
- Repeat rd 8'h05 -> odv and rdata=8'hA5 at cycle 1; no ram_re.
- rd 8'h09 (same index 1, tag differs) after 8'h05 -> miss, refill; a following rd 8'h05 misses again (eviction).
- wr 8'h05=8'h3C on a cached line -> ram_we pulse at cycle 1 with ram_addr=8'h05, ram_wdata=8'h3C; odv at cycle 2; next rd 8'h05 hits with rdata=8'h3C.
- wr 8'h20=8'h11 (miss), then rd 8'h20 -> read misses and fetches 8'h11 (no allocate); rd and wr asserted together -> only the write performed.
- Assert g_clr low during WAIT -> no odv; busy=0; subsequent rd of the same address misses (valid cleared).
